serial_tx_piso: RTL and testbench

SERIAL_TX_PISO -- requirements
Module: serial_tx_piso

---
 rtl/serial_tx_piso.sv | 180 ++++++++++++++++++
 tb/tb_serial_tx_piso.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_piso.sv
// serial_tx_piso: parallel-in serial-out transmitter.
// Frame: start (0), WIDTH data bits (LSB_FIRST order), optional parity, stop (1).
// Define SERIAL_TX_PARITY_EN to add an even-parity bit after the data bits.
// The first IDLE cycle (tx_done) doubles as the last stop-bit cycle, so a new
// word can be accepted there without an extra idle bit on the line.
module serial_tx_piso #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned LSB_FIRST    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             tx_busy,
    output logic             tx_done
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_e;
`endif

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             dout_q, dout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
    logic             par_q, par_d;
`endif
    logic             bit_end_c;
    logic             to_stop_c;

    // Data bit n of the latched word in transmit order
    function automatic logic pick(input logic [WIDTH-1:0] w, input logic [BW-1:0] n);
        logic [BW-1:0]    idx;
        logic [WIDTH-1:0] s;
        idx = (LSB_FIRST != 0) ? n : B_LAST - n;
        s   = w >> idx;
        return s[0];
    endfunction

    assign bit_end_c = (timer_q == T_LAST);
    assign din_ready = (state_q == S_IDLE);
    assign dout      = dout_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

    // Next-state, bit timing and registered-output decode
    always_comb begin
        state_d   = state_q;
        timer_d   = bit_end_c ? '0 : timer_q + TW'(1);
        bit_d     = bit_q;
        buf_d     = buf_q;
        dout_d    = dout_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        to_stop_c = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (din_valid) begin
                    state_d = S_START;
                    buf_d   = din;
                    bit_d   = '0;
                    dout_d  = 1'b0;
                    busy_d  = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = ^din;
`endif
                end
            end
            S_START: begin
                if (bit_end_c) begin
                    state_d = S_DATA;
                    dout_d  = pick(buf_q, BW'(0));
                end
            end
            S_DATA: begin
                if (bit_end_c) begin
                    if (bit_q == B_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
                        dout_d  = par_q;
`else
                        to_stop_c = 1'b1;
`endif
                    end else begin
                        bit_d  = bit_q + BW'(1);
                        dout_d = pick(buf_q, bit_q + BW'(1));
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end_c) begin
                    to_stop_c = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end_c) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                dout_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
        // Stop bit: its final cycle is the tx_done IDLE cycle, so STOP starts mid-count
        if (to_stop_c) begin
            dout_d = 1'b1;
            if (CLKS_PER_BIT == 1) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = S_STOP;
                timer_d = TW'(1);
            end
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            buf_q   <= '0;
            dout_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            buf_q   <= buf_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_tx_piso.sv
// Self-checking bench for serial_tx_piso: three configurations
// (8-bit LSB-first, 8-bit MSB-first, 1-bit at one clock per bit).
module tb_serial_tx_piso;

`ifdef SERIAL_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [7:0] a_din, m_din;
    logic [0:0] t_din;
    logic a_valid, a_ready, a_dout, a_busy, a_done;
    logic m_valid, m_ready, m_dout, m_busy, m_done;
    logic t_valid, t_ready, t_dout, t_busy, t_done;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    serial_tx_piso #(.WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(1)) u_lsb (
        .clk(clk), .reset(reset), .din(a_din), .din_valid(a_valid),
        .din_ready(a_ready), .dout(a_dout), .tx_busy(a_busy), .tx_done(a_done));

    serial_tx_piso #(.WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(0)) u_msb (
        .clk(clk), .reset(reset), .din(m_din), .din_valid(m_valid),
        .din_ready(m_ready), .dout(m_dout), .tx_busy(m_busy), .tx_done(m_done));

    serial_tx_piso #(.WIDTH(1), .CLKS_PER_BIT(1), .LSB_FIRST(1)) u_tiny (
        .clk(clk), .reset(reset), .din(t_din), .din_valid(t_valid),
        .din_ready(t_ready), .dout(t_dout), .tx_busy(t_busy), .tx_done(t_done));

    function automatic int cfg_width(input int inst);
        return (inst == 2) ? 1 : 8;
    endfunction

    function automatic int cfg_cpb(input int inst);
        return (inst == 2) ? 1 : 4;
    endfunction

    function automatic bit cfg_lsb(input int inst);
        return (inst == 1) ? 1'b0 : 1'b1;
    endfunction

    // {dout, tx_busy, tx_done, din_ready}
    function automatic logic [3:0] obs(input int inst);
        case (inst)
            0:       return {a_dout, a_busy, a_done, a_ready};
            1:       return {m_dout, m_busy, m_done, m_ready};
            default: return {t_dout, t_busy, t_done, t_ready};
        endcase
    endfunction

    task automatic drive(input int inst, input logic v, input logic [7:0] d);
        case (inst)
            0:       begin a_valid = v; a_din = d; end
            1:       begin m_valid = v; m_din = d; end
            default: begin t_valid = v; t_din = d[0]; end
        endcase
    endtask

    // Line level expected k cycles after the accept edge (k >= 1)
    function automatic logic model_dout(input logic [7:0] w, input int wd, input int cpb,
                                        input bit lsb, input int k);
        int b;
        b = (k - 1) / cpb;
        if (b == 0) return 1'b0;
        if (b <= wd) return lsb ? w[b-1] : w[wd-b];
        if (P == 1 && b == wd + 1) begin
            logic p;
            p = 1'b0;
            for (int i = 0; i < wd; i++) p = p ^ w[i];
            return p;
        end
        return 1'b1;
    endfunction

    // Send one word and check every cycle up to and including the tx_done cycle.
    // pre: word already presented (accepted at next edge); pulses: random din_valid
    // while busy; chain: present nxt in the tx_done cycle.
    task automatic run_frame(input int inst, input logic [7:0] w, input bit pre,
                             input bit pulses, input bit chain, input logic [7:0] nxt);
        int wd, cpb, len;
        logic [3:0] o, e;
        wd  = cfg_width(inst);
        cpb = cfg_cpb(inst);
        len = (wd + 2 + P) * cpb;
        if (!pre) begin
            @(negedge clk);
            drive(inst, 1'b1, w);
            o = obs(inst);
            vectors++;
            if (o !== 4'b1001) begin
                errors++;
                $display("FAIL idle_before_accept inst=%0d got %b want 1001", inst, o);
            end
        end
        @(posedge clk);
        #1 drive(inst, 1'b0, 8'($urandom));
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            e = {model_dout(w, wd, cpb, cfg_lsb(inst), k), k < len, k == len, k >= len};
            o = obs(inst);
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL frame inst=%0d word=%h cycle=%0d {dout,busy,done,ready} got %b want %b",
                         inst, w, k, o, e);
            end
            if (k == len) drive(inst, chain, nxt);
            else if (pulses) drive(inst, 1'($urandom), 8'($urandom));
        end
    endtask

    task automatic test_reset();
        logic [3:0] o;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            for (int inst = 0; inst < 3; inst++) begin
                o = obs(inst);
                vectors++;
                if (o !== 4'b1001) begin
                    errors++;
                    $display("FAIL reset_state pass=%0d inst=%0d got %b want 1001", pass, inst, o);
                end
            end
            reset = 1'b1;
        end
    endtask

    task automatic test_single_frame();
        run_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
        run_frame(0, 8'h07, 1'b0, 1'b0, 1'b0, 8'h00);
        run_frame(0, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) run_frame(0, 8'($urandom), 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_msb_first();
        run_frame(1, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) run_frame(1, 8'($urandom), 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_tiny();
        run_frame(2, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00);
        run_frame(2, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01);
        run_frame(2, 8'h01, 1'b1, 1'b1, 1'b1, 8'h00);
        run_frame(2, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [7:0] w, n;
        run_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'hC3);
        run_frame(0, 8'hC3, 1'b1, 1'b1, 1'b0, 8'h00);
        w = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            n = 8'($urandom);
            run_frame(1, w, i != 0, 1'b1, i != 2, n);
            w = n;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        logic [3:0] o, e;
        w = 8'($urandom);
        @(negedge clk);
        drive(0, 1'b1, w);
        @(posedge clk);
        #1 drive(0, 1'b0, 8'h00);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            e = {model_dout(w, 8, 4, 1'b1, k), 1'b1, 1'b0, 1'b0};
            o = obs(0);
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL pre_reset_frame cycle=%0d got %b want %b", k, o, e);
            end
        end
        reset = 1'b0;
        drive(0, 1'b1, 8'hFF);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            o = obs(0);
            vectors++;
            if (o !== 4'b1001) begin
                errors++;
                $display("FAIL reset_abort step=%0d got %b want 1001", c, o);
            end
            if (c == 0) begin
                @(posedge clk);
                #1 begin reset = 1'b1; drive(0, 1'b0, 8'h00); end
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            o = obs(0);
            vectors++;
            if (o !== 4'b1001) begin
                errors++;
                $display("FAIL post_reset_idle step=%0d got %b want 1001", c, o);
            end
        end
        run_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        reset   = 1'b0;
        a_valid = 1'b0; a_din = '0;
        m_valid = 1'b0; m_din = '0;
        t_valid = 1'b0; t_din = '0;
        test_reset();
        test_single_frame();
        test_msb_first();
        test_tiny();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
